// File: rtl/alu_pkg.sv
// Shared definitions for the ALU result stage: NZCV bit positions,
// occupancy encoding and a flag-packing helper.
package alu_pkg;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  localparam logic [1:0] EMPTY = 2'd0;
  localparam logic [1:0] ONE   = 2'd1;
  localparam logic [1:0] FULL  = 2'd2;

  function automatic logic [3:0] make_flags(input logic n, input logic z,
                                            input logic c, input logic v);
    logic [3:0] f;
    f         = '0;
    f[FLAG_N] = n;
    f[FLAG_Z] = z;
    f[FLAG_C] = c;
    f[FLAG_V] = v;
    return f;
  endfunction

endpackage

// File: rtl/alu_flag_calc.sv
// Combinational NZCV derivation for one ALU result.
module alu_flag_calc
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] result,
  input  logic             carry,
  input  logic             overflow,
  output logic [3:0]       flags
);

  assign flags = make_flags(result[WIDTH-1], (result == '0), carry, overflow);

endmodule

// File: rtl/alu_result_stage.sv
// Registered ALU output stage: two-entry skid buffer with per-entry NZCV
// flags and the architectural flag register updated on hand-off.
module alu_result_stage
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int RD_W  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_result,
  input  logic             in_carry,
  input  logic             in_overflow,
  input  logic             in_set_flags,
  input  logic [RD_W-1:0]  in_rd,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic [RD_W-1:0]  out_rd,
  output logic [3:0]       out_flags,
  output logic [3:0]       cpsr_flags
);

  typedef struct packed {
    logic             set_flags;
    logic [RD_W-1:0]  rd;
    logic [3:0]       flags;
    logic [WIDTH-1:0] result;
  } entry_t;

  entry_t     head_q, skid_q, new_entry;
  logic [1:0] state_q, state_d;
  logic [3:0] in_flags;
  logic       accept, pop;

  alu_flag_calc #(.WIDTH(WIDTH)) u_flag_calc (
    .result   (in_result),
    .carry    (in_carry),
    .overflow (in_overflow),
    .flags    (in_flags)
  );

  assign new_entry = '{set_flags: in_set_flags, rd: in_rd,
                       flags: in_flags, result: in_result};

  assign accept     = in_valid & in_ready;
  assign pop        = out_valid & out_ready;
  assign out_valid  = (state_q != EMPTY);
  assign out_result = head_q.result;
  assign out_rd     = head_q.rd;
  assign out_flags  = head_q.flags;

  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY: if (accept) state_d = ONE;
      ONE: begin
        if (accept && !pop)      state_d = FULL;
        else if (!accept && pop) state_d = EMPTY;
      end
      FULL:    if (pop) state_d = ONE;
      default: state_d = EMPTY;
    endcase
  end

  // in_ready is registered from the next state, so out_ready never reaches it combinationally
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= EMPTY;
      in_ready   <= 1'b1;
      head_q     <= '0;
      skid_q     <= '0;
      cpsr_flags <= '0;
    end else begin
      state_q  <= state_d;
      in_ready <= (state_d != FULL);
      if (pop && head_q.set_flags) cpsr_flags <= head_q.flags;
      case (state_q)
        EMPTY: if (accept) head_q <= new_entry;
        ONE: begin
          if (accept && pop) head_q <= new_entry;
          else if (accept)   skid_q <= new_entry;
        end
        FULL:    if (pop) head_q <= skid_q;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_result_stage.sv
// Directed bench for alu_result_stage: a per-cycle vector table followed by
// back-pressure, streaming and asynchronous-reset sequences.
module tb_alu_result_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, in_carry, in_overflow, in_set_flags;
  logic [31:0] in_result;
  logic [3:0]  in_rd;
  logic        out_valid, out_ready;
  logic [31:0] out_result;
  logic [3:0]  out_rd, out_flags, cpsr_flags;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic        valid;
    logic [31:0] res;
    logic        c;
    logic        v;
    logic        sf;
    logic [3:0]  rd;
    logic        ordy;
    logic        e_valid;
    logic        e_ready;
    logic [31:0] e_res;
    logic [3:0]  e_rd;
    logic [3:0]  e_flags;
    logic [3:0]  e_cpsr;
  } vec_t;

  vec_t vecs[8];

  always #5 clk = ~clk;

  alu_result_stage #(.WIDTH(32), .RD_W(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_result    (in_result),
    .in_carry     (in_carry),
    .in_overflow  (in_overflow),
    .in_set_flags (in_set_flags),
    .in_rd        (in_rd),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_result   (out_result),
    .out_rd       (out_rd),
    .out_flags    (out_flags),
    .cpsr_flags   (cpsr_flags)
  );

  task automatic applyStimulus(input vec_t v);
    in_valid     = v.valid;
    in_result    = v.res;
    in_carry     = v.c;
    in_overflow  = v.v;
    in_set_flags = v.sf;
    in_rd        = v.rd;
    out_ready    = v.ordy;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic valid, input logic [31:0] res, input logic sf,
                       input logic ordy);
    vec_t v;
    v       = '{default: '0};
    v.valid = valid;
    v.res   = res;
    v.sf    = sf;
    v.c     = 1'b1;
    v.rd    = res[3:0];
    v.ordy  = ordy;
    applyStimulus(v);
  endtask

  initial begin
    vecs[0] = '{1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b1, 4'd3,  1'b1,
                1'b1, 1'b1, 32'h0000_0000, 4'd3,  4'b0110, 4'b0000};
    vecs[1] = '{1'b1, 32'h8000_0001, 1'b0, 1'b1, 1'b0, 4'd5,  1'b1,
                1'b1, 1'b1, 32'h8000_0001, 4'd5,  4'b1001, 4'b0110};
    vecs[2] = '{1'b0, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 4'd0,  1'b1,
                1'b0, 1'b1, 32'h0000_0000, 4'd0,  4'b0000, 4'b0110};
    vecs[3] = '{1'b1, 32'hFFFF_FFFF, 1'b1, 1'b1, 1'b1, 4'd15, 1'b0,
                1'b1, 1'b1, 32'hFFFF_FFFF, 4'd15, 4'b1011, 4'b0110};
    vecs[4] = '{1'b0, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 4'd0,  1'b1,
                1'b0, 1'b1, 32'h0000_0000, 4'd0,  4'b0000, 4'b1011};
    vecs[5] = '{1'b1, 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b1, 4'd1,  1'b1,
                1'b1, 1'b1, 32'h7FFF_FFFF, 4'd1,  4'b0001, 4'b1011};
    vecs[6] = '{1'b1, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 4'd2,  1'b1,
                1'b1, 1'b1, 32'h0000_0000, 4'd2,  4'b0100, 4'b0001};
    vecs[7] = '{1'b0, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 4'd0,  1'b1,
                1'b0, 1'b1, 32'h0000_0000, 4'd0,  4'b0000, 4'b0001};

    rst_n = 1'b0;
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    checkOutput("reset in_ready",   32'(in_ready),   32'd1);
    checkOutput("reset out_valid",  32'(out_valid),  32'd0);
    checkOutput("reset out_result", out_result,      32'd0);
    checkOutput("reset out_rd",     32'(out_rd),     32'd0);
    checkOutput("reset out_flags",  32'(out_flags),  32'd0);
    checkOutput("reset cpsr",       32'(cpsr_flags), 32'd0);
    rst_n = 1'b1;

    // Table: one vector per cycle, checked on the following negedge
    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[i]);
      @(negedge clk);
      checkOutput($sformatf("vec%0d out_valid", i), 32'(out_valid), 32'(vecs[i].e_valid));
      checkOutput($sformatf("vec%0d in_ready", i),  32'(in_ready),  32'(vecs[i].e_ready));
      checkOutput($sformatf("vec%0d cpsr", i),      32'(cpsr_flags), 32'(vecs[i].e_cpsr));
      if (vecs[i].e_valid) begin
        checkOutput($sformatf("vec%0d out_result", i), out_result,           vecs[i].e_res);
        checkOutput($sformatf("vec%0d out_rd", i),     32'(out_rd),          32'(vecs[i].e_rd));
        checkOutput($sformatf("vec%0d out_flags", i),  32'(out_flags),       32'(vecs[i].e_flags));
      end
    end

    // Back-pressure: A and B fill the buffer, C waits, then drain in order
    drive(1'b1, 32'd1, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("bp A head", out_result, 32'd1);
    checkOutput("bp A ready", 32'(in_ready), 32'd1);
    drive(1'b1, 32'd2, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("bp full ready", 32'(in_ready), 32'd0);
    checkOutput("bp full head", out_result, 32'd1);
    drive(1'b1, 32'd3, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("bp C held ready", 32'(in_ready), 32'd0);
    checkOutput("bp C held head", out_result, 32'd1);
    drive(1'b1, 32'd3, 1'b0, 1'b1);
    @(negedge clk);
    checkOutput("bp pop1 head", out_result, 32'd2);
    checkOutput("bp pop1 ready", 32'(in_ready), 32'd1);
    checkOutput("bp pop1 valid", 32'(out_valid), 32'd1);
    @(negedge clk);
    checkOutput("bp pop2 head", out_result, 32'd3);
    checkOutput("bp pop2 valid", 32'(out_valid), 32'd1);
    drive(1'b0, 32'd0, 1'b0, 1'b1);
    @(negedge clk);
    checkOutput("bp drained valid", 32'(out_valid), 32'd0);
    checkOutput("bp cpsr kept", 32'(cpsr_flags), 32'b0001);

    // Streaming: one result per cycle, never back-pressured
    for (int i = 0; i <= 8; i++) begin
      if (i < 8) drive(1'b1, 32'(i), 1'b0, 1'b1);
      else       drive(1'b0, 32'd0, 1'b0, 1'b1);
      @(negedge clk);
      if (i < 8) begin
        checkOutput($sformatf("stream%0d result", i), out_result, 32'(i));
        checkOutput($sformatf("stream%0d valid", i), 32'(out_valid), 32'd1);
        checkOutput($sformatf("stream%0d ready", i), 32'(in_ready), 32'd1);
      end else begin
        checkOutput("stream end valid", 32'(out_valid), 32'd0);
      end
    end

    // Asynchronous reset with two flag-setting entries buffered
    drive(1'b1, 32'h0000_0000, 1'b1, 1'b0);
    @(negedge clk);
    drive(1'b1, 32'h8000_0000, 1'b1, 1'b0);
    @(negedge clk);
    checkOutput("prereset full", 32'(in_ready), 32'd0);
    drive(1'b0, 32'd0, 1'b0, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("async rst valid", 32'(out_valid), 32'd0);
    checkOutput("async rst ready", 32'(in_ready), 32'd1);
    checkOutput("async rst cpsr", 32'(cpsr_flags), 32'd0);
    checkOutput("async rst result", out_result, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) begin
      @(negedge clk);
      checkOutput("post rst valid", 32'(out_valid), 32'd0);
      checkOutput("post rst cpsr", 32'(cpsr_flags), 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
